adder_chunked: RTL and testbench
================================

# adder_chunked

Multi-cycle, parametrised N-bit adder/subtractor that processes CHUNK bits per clock through one ripple-carry slice. It carries between chunks in a register and trades latency for area. It has valid/ready handshakes on both sides, so it can sit between a register-file or counter datapath and any consumer that stalls. It extends the combinational adder_n with width, chunking, a subtract mode, signed-overflow detection and flow control.

## Interface
- N, default 32: operand/result width; must be a positive multiple of CHUNK.
- CHUNK, default 8: bits added per cycle; NCHUNK = N/CHUNK.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- i_valid  in  1  operands presented.
- i_ready  out  1  block can accept operands.
- a  in  N  operand A, unsigned or two's complement.
- b  in  N  operand B.
- c_in  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+c_in; 1: a-b (a + ~b + 1).
- o_valid  out  1  result available.
- o_ready  in  1  consumer takes result.
- sum  out  N  result modulo 2^N.
- c_out  out  1  carry out of bit N-1; in subtract mode, 1 means no borrow.
- overflow  out  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: i_ready=1, o_valid=0. On i_valid&&i_ready, latch the following and go to BUSY:
  - a.
  - b, or ~b when sub=1.
  - carry = sub ? 1 : c_in.
  - chunk index cnt=0.
- BUSY: each cycle adds chunk cnt, bits [cnt*CHUNK +: CHUNK], with the registered carry.
  - Write that slice of sum.
  - Update the carry register.
  - When cnt==NCHUNK-1, record the carry into bit N-1 for the overflow flag, then go to DONE. Otherwise cnt++.
  - i_ready=0.
- DONE: o_valid=1; sum, c_out and overflow are held stable. On o_valid&&o_ready, go to IDLE. i_ready=0 in DONE; no accept occurs in the same cycle as the transfer.
- Inputs a/b/c_in/sub are sampled only on the accept edge; later changes have no effect.
- Arithmetic: all widths are exact N. No sign extension. sum wraps modulo 2^N.
- N==CHUNK is legal: BUSY lasts one cycle.
- i_valid while not in IDLE is ignored and is not queued. o_ready outside DONE is ignored.

## Timing
- Reset (async assert, sync release):
  - State: IDLE.
  - i_ready=1, o_valid=0.
  - sum=0, c_out=0, overflow=0.
  - cnt=0, carry=0.
- Reset mid-BUSY or mid-DONE aborts the operation; no result is produced.
- Latency: accept at edge k gives o_valid=1 after edge k+NCHUNK.
- Minimum issue period is NCHUNK+2 cycles: accept, NCHUNK adds, transfer.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Outputs are stable throughout DONE regardless of o_ready duration.

## Structure
- Package adder_pkg:
  - state_t enum (IDLE, BUSY, DONE).
  - Function nchunks(N, CHUNK).
  - Elaboration check: N % CHUNK == 0.
- One sub-module: adder_n, parametrised to width CHUNK, instanced once as the per-cycle slice (ports a, b, c_in, sum, c_out).
- The overflow carry-in comes from the slice's MSB internal carry. adder_n exposes it as an optional c_msb output, or the block derives it as sum[N-1]^a[N-1]^b_eff[N-1].
- cnt width is $clog2(NCHUNK), minimum 1.

## Test plan
- N=8, CHUNK=4, add a=8'hFF b=8'h01 c_in=0:
  - Expected: sum=8'h00, c_out=1, overflow=0.
  - o_valid rises exactly 2 cycles after accept.
  - i_ready=0 until transfer.
- N=8, CHUNK=4, add a=8'h7F b=8'h01 c_in=0:
  - Expected: sum=8'h80, c_out=0, overflow=1.
  - Then a=8'h80 b=8'h80: sum=8'h00, c_out=1, overflow=1.
- N=8, CHUNK=4, sub=1, a=8'h05 b=8'h07, c_in=1 (must be ignored):
  - Expected: sum=8'hFE, c_out=0, overflow=0.
- Backpressure, N=32, CHUNK=8, a=32'h0000_FFFF b=32'h0000_0001 c_in=1:
  - Hold o_ready=0 for 5 cycles in DONE.
  - sum=32'h0001_0001 and o_valid stay stable.
  - Change a/b during BUSY: result unchanged.
  - Transfer returns to IDLE; i_ready=1 on the next cycle.
- Reset mid-operation:
  - Assert rst asynchronously 1 cycle after accept.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, a fresh a=8'h10 b=8'h20 yields sum=8'h30 with no residue from the aborted carry.
- Degenerate case N=CHUNK=4, a=4'hF b=4'hF c_in=1:
  - Expected: sum=4'hF, c_out=1, overflow=0.
  - Latency is 1 cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked adder and its ripple slice.
package adder_pkg;

    // Control states of the chunked adder: waiting, adding chunks, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slice additions needed to cover the full operand width.
    function automatic int nchunks(input int n, input int chunk);
        return n / chunk;
    endfunction

    // Legal parameter sets: both positive and the width an exact multiple of the chunk.
    function automatic bit paramsOk(input int n, input int chunk);
        return (n > 0) && (chunk > 0) && ((n % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_n.sv
// Combinational W-bit ripple-carry adder used as the per-cycle slice.
// Besides the carry out it exposes the carry into the MSB so the caller
// can form the signed-overflow flag without re-deriving it.
module adder_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         c_msb
);

    logic [W:0] w_carry;

    // Ripple the carry bit by bit from c_in up to the slice MSB.
    always_comb begin
        sum        = '0;
        w_carry    = '0;
        w_carry[0] = c_in;
        for (int i = 0; i < W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = w_carry[W];
    assign c_msb = w_carry[W-1];

endmodule

// File: rtl/adder_chunked.sv
// Multi-cycle N-bit adder/subtractor: one CHUNK-wide ripple slice is reused
// NCHUNK times, with the inter-chunk carry kept in a register. Operands are
// captured on accept, so the producer may change them freely afterwards.
module adder_chunked
    import adder_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow
);

    localparam int NCHUNK = nchunks(N, CHUNK);
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Refuse to elaborate with a width that does not split into whole chunks.
    if (!paramsOk(N, CHUNK)) begin : g_badParams
        $error("adder_chunked: N must be a positive multiple of CHUNK");
    end

    state_t          r_state;
    state_t          w_nextState;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_sum;
    logic            r_cOut;
    logic            r_ovf;

    logic [CHUNK-1:0] w_sliceA;
    logic [CHUNK-1:0] w_sliceB;
    logic [CHUNK-1:0] w_sliceSum;
    logic             w_sliceCout;
    logic             w_sliceCmsb;
    logic             w_accept;
    logic             w_lastChunk;

    assign w_accept    = i_valid && (r_state == IDLE);
    assign w_lastChunk = (r_cnt == CW'(NCHUNK - 1));

    // Select the operand chunk addressed by the chunk counter.
    always_comb begin
        w_sliceA = '0;
        w_sliceB = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_cnt == CW'(k)) begin
                w_sliceA = r_a[k*CHUNK +: CHUNK];
                w_sliceB = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    adder_n #(
        .W (CHUNK)
    ) u_slice (
        .a     (w_sliceA),
        .b     (w_sliceB),
        .c_in  (r_carry),
        .sum   (w_sliceSum),
        .c_out (w_sliceCout),
        .c_msb (w_sliceCmsb)
    );

    // State register; reset aborts whatever operation is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: accept in IDLE, step through chunks, hand off in DONE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (w_lastChunk) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (o_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, then write one sum chunk per BUSY
    // cycle; the final chunk also latches carry-out and the overflow flag.
    // Subtraction is folded in at capture time as a + ~b + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cOut  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_cnt   <= '0;
        end else if (r_state == BUSY) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (r_cnt == CW'(k)) begin
                    r_sum[k*CHUNK +: CHUNK] <= w_sliceSum;
                end
            end
            r_carry <= w_sliceCout;
            if (w_lastChunk) begin
                r_cOut <= w_sliceCout;
                r_ovf  <= w_sliceCmsb ^ w_sliceCout;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign i_ready  = (r_state == IDLE);
    assign o_valid  = (r_state == DONE);
    assign sum      = r_sum;
    assign c_out    = r_cOut;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_adder_chunked.sv
// Scoreboard bench for adder_chunked: three instances (32/8, 8/4, 4/4) share
// one stimulus driver and one monitor, selected by 'sel'.
module tb_adder_chunked;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acceptEdge;
        bit          seen;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic        drvValid;
    logic [31:0] drvA;
    logic [31:0] drvB;
    logic        drvCin;
    logic        drvSub;
    logic        oReadyDrv;
    int          stallCycles;
    bit          randReady;
    int          cycleCount;
    int          checks;
    int          failures;
    bit          checkReadyNow;
    exp_t        sbQ[$];

    logic        iv0, ir0, ov0, or0, co0, of0;
    logic        iv1, ir1, ov1, or1, co1, of1;
    logic        iv2, ir2, ov2, or2, co2, of2;
    logic [31:0] s0;
    logic [7:0]  s1;
    logic [3:0]  s2;

    logic        monValid, monReady, monCout, monOvf;
    logic [31:0] monSum;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Edge counter used to measure accept-to-valid latency.
    initial cycleCount = 0;
    always @(posedge clk) cycleCount++;

    assign iv0 = drvValid && (sel == 0);
    assign iv1 = drvValid && (sel == 1);
    assign iv2 = drvValid && (sel == 2);
    assign or0 = oReadyDrv && (sel == 0);
    assign or1 = oReadyDrv && (sel == 1);
    assign or2 = oReadyDrv && (sel == 2);

    adder_chunked #(.N(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .i_valid(iv0), .i_ready(ir0),
        .a(drvA), .b(drvB), .c_in(drvCin), .sub(drvSub),
        .o_valid(ov0), .o_ready(or0), .sum(s0), .c_out(co0), .overflow(of0)
    );

    adder_chunked #(.N(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst(rst), .i_valid(iv1), .i_ready(ir1),
        .a(drvA[7:0]), .b(drvB[7:0]), .c_in(drvCin), .sub(drvSub),
        .o_valid(ov1), .o_ready(or1), .sum(s1), .c_out(co1), .overflow(of1)
    );

    adder_chunked #(.N(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(iv2), .i_ready(ir2),
        .a(drvA[3:0]), .b(drvB[3:0]), .c_in(drvCin), .sub(drvSub),
        .o_valid(ov2), .o_ready(or2), .sum(s2), .c_out(co2), .overflow(of2)
    );

    // Route the selected instance's outputs onto the monitor's view.
    always_comb begin
        monValid = ov0; monReady = ir0; monSum = s0; monCout = co0; monOvf = of0;
        if (sel == 1) begin
            monValid = ov1; monReady = ir1; monSum = {24'd0, s1}; monCout = co1; monOvf = of1;
        end else if (sel == 2) begin
            monValid = ov2; monReady = ir2; monSum = {28'd0, s2}; monCout = co2; monOvf = of2;
        end
    end

    function automatic int widthOf(input int s);
        return (s == 0) ? 32 : (s == 1) ? 8 : 4;
    endfunction

    function automatic int nchOf(input int s);
        return (s == 0) ? 4 : (s == 1) ? 2 : 1;
    endfunction

    // Reference model from plain integer arithmetic: unsigned result for sum and
    // carry/no-borrow, signed range test for overflow.
    function automatic exp_t model(input int n, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t r;
        longint modv = longint'(1) << n;
        longint half = longint'(1) << (n - 1);
        longint ua   = longint'(a) & (modv - 1);
        longint ub   = longint'(b) & (modv - 1);
        longint sa   = (ua >= half) ? ua - modv : ua;
        longint sb   = (ub >= half) ? ub - modv : ub;
        longint ures;
        longint sres;
        if (sub) begin
            ures   = ua - ub;
            sres   = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            ures   = ua + ub + longint'(cin);
            sres   = sa + sb + longint'(cin);
            r.cout = (ures >= modv);
        end
        r.sum        = 32'(((ures % modv) + modv) % modv);
        r.ovf        = (sres < -half) || (sres > half - 1);
        r.acceptEdge = 0;
        r.seen       = 0;
        return r;
    endfunction

    // Single comparison point: counts every check and reports any miss.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (sel=%0d t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    // Issue one operation: hold i_valid until the DUT is ready, record the
    // expectation after the accept edge, then scramble inputs during BUSY.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        drvA = a; drvB = b; drvCin = cin; drvSub = sub; drvValid = 1'b1;
        while (monReady !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            drvValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        drvValid     = 1'b0;
        e            = model(widthOf(sel), a, b, cin, sub);
        e.acceptEdge = cycleCount;
        sbQ.push_back(e);
        drvA = $urandom; drvB = $urandom; drvCin = 1'($urandom); drvSub = 1'($urandom);
    endtask

    // Block until every issued operation has been transferred and the DUT idles.
    task automatic waitIdle();
        int waited = 0;
        @(negedge clk);
        while ((sbQ.size() != 0 || monReady !== 1'b1) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 500) begin
            checkOutput("drainTimeout", 32'd0, 32'd1);
            sbQ.delete();
        end
        @(negedge clk);
    endtask

    // Consumer: forced stalls first, otherwise always-ready or random ready.
    always @(posedge clk) begin
        #2;
        if (stallCycles > 0 && monValid === 1'b1) begin
            oReadyDrv = 1'b0;
            stallCycles--;
        end else begin
            oReadyDrv = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares held results against the scoreboard head every DONE
    // cycle, checks latency on the first valid cycle, handshake levels while
    // busy, and that the block is ready right after each transfer.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (checkReadyNow) begin
                checkOutput("readyAfterXfer", 32'(monReady), 32'd1);
                checkReadyNow = 0;
            end
            if (monValid === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedValid", 32'(monValid), 32'd0);
                end else begin
                    if (!sbQ[0].seen) begin
                        checkOutput("latency", 32'(cycleCount - sbQ[0].acceptEdge), 32'(nchOf(sel)));
                        sbQ[0].seen = 1;
                    end
                    checkOutput("sum", monSum, sbQ[0].sum);
                    checkOutput("c_out", 32'(monCout), 32'(sbQ[0].cout));
                    checkOutput("overflow", 32'(monOvf), 32'(sbQ[0].ovf));
                    checkOutput("readyInDone", 32'(monReady), 32'd0);
                    if (oReadyDrv === 1'b1) begin
                        void'(sbQ.pop_front());
                        checkReadyNow = 1;
                    end
                end
            end else if (sbQ.size() != 0) begin
                checkOutput("readyInBusy", 32'(monReady), 32'd0);
            end
        end
    end

    // Main sequence: reset values, directed corner cases, backpressure,
    // mid-operation reset, then randomized traffic on every instance.
    initial begin
        rst = 1'b1; sel = 0; drvValid = 1'b0; drvA = '0; drvB = '0;
        drvCin = 1'b0; drvSub = 1'b0; oReadyDrv = 1'b1; stallCycles = 0;
        randReady = 0; checks = 0; failures = 0; checkReadyNow = 0;

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput("rstValid", 32'(monValid), 32'd0);
            checkOutput("rstReady", 32'(monReady), 32'd1);
            checkOutput("rstSum", monSum, 32'd0);
            checkOutput("rstCout", 32'(monCout), 32'd0);
            checkOutput("rstOvf", 32'(monOvf), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        sel = 1;
        applyStimulus(32'hFF, 32'h01, 1'b0, 1'b0);
        applyStimulus(32'h7F, 32'h01, 1'b0, 1'b0);
        applyStimulus(32'h80, 32'h80, 1'b0, 1'b0);
        applyStimulus(32'h05, 32'h07, 1'b1, 1'b1);
        waitIdle();

        applyStimulus(32'h12, 32'h34, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        sbQ.delete();
        checkReadyNow = 0;
        #1;
        checkOutput("abortValid", 32'(monValid), 32'd0);
        checkOutput("abortReady", 32'(monReady), 32'd1);
        checkOutput("abortSum", monSum, 32'd0);
        checkOutput("abortCout", 32'(monCout), 32'd0);
        checkOutput("abortOvf", 32'(monOvf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h10, 32'h20, 1'b0, 1'b0);
        waitIdle();

        sel = 0;
        stallCycles = 5;
        applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        waitIdle();
        randReady = 1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        waitIdle();

        sel = 1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        waitIdle();

        sel = 2;
        randReady = 0;
        applyStimulus(32'hF, 32'hF, 1'b1, 1'b0);
        randReady = 1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
